// File: rtl/ln_range_reduce.sv
// ln_range_reduce: serial leading-one normaliser feeding the ln(1+x) evaluator.
// Splits an unsigned operand a into a = 2^e * (1 + f). It returns f as a
// Q(FB) fraction in a signed (W+1)-bit container and e as an EW-bit exponent,
// so the next stage can form ln(a) = e*ln2 + ln(1+f).
// The operand shifts left one bit per clock until its MSB is set.
//
// Handshake: start is accepted only in IDLE, where busy=0 and valid=0.
// busy is high from the accepting edge up to the edge that raises valid.
// valid is a single-cycle pulse, and frac_out/exp_out/zero_err are meaningful
// while it is high; they hold their values until the next result.
// A start seen while busy or valid is dropped and is not queued.
//
// Optional build macro LN_RR_ROUND_EN: rounds the fraction to nearest using the
// first discarded bit, saturating at 2^FB-1. When the macro is undefined the
// fraction is truncated toward zero.
module ln_range_reduce #(
   parameter int WA = 32,
   parameter int W  = 17,
   parameter int FB = 16,
   parameter int EW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [WA-1:0] a_in,
   output logic          busy,
   output logic          valid,
   output logic [W:0]    frac_out,
   output logic [EW-1:0] exp_out,
   output logic          zero_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] NORM = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [WA-1:0] r;
   logic [EW-1:0] cnt;
   logic [FB-1:0] frac_next;

`ifdef LN_RR_ROUND_EN
   logic [FB:0] frac_sum;

   // Round to nearest on the first dropped bit; clamp instead of carrying into e.
   always_comb begin
      frac_sum  = {1'b0, r[WA-2 -: FB]} + {{FB{1'b0}}, r[WA-2-FB]};
      frac_next = frac_sum[FB] ? {FB{1'b1}} : frac_sum[FB-1:0];
   end
`else
   // Bits below the FB fraction bits are simply discarded.
   assign frac_next = r[WA-2 -: FB];
`endif

   // Control FSM plus the shift register, the shift counter and the result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         r        <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         valid    <= 1'b0;
         zero_err <= 1'b0;
         frac_out <= '0;
         exp_out  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  r     <= a_in;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= NORM;
               end
            end
            NORM: begin
               if (r == '0) begin
                  zero_err <= 1'b1;
                  frac_out <= '0;
                  exp_out  <= '0;
                  busy     <= 1'b0;
                  valid    <= 1'b1;
                  state    <= DONE;
               end else if (r[WA-1]) begin
                  exp_out  <= EW'(WA-1) - cnt;
                  frac_out <= {{(W+1-FB){1'b0}}, frac_next};
                  zero_err <= 1'b0;
                  busy     <= 1'b0;
                  valid    <= 1'b1;
                  state    <= DONE;
               end else begin
                  r   <= r << 1;
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               valid <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
